// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave = the unit itself; master = the pipeline/memory environment driving it.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_misaligned;
    logic                  resp_illegal;
    logic                  mem_we;
    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        output mem_we, mem_valid, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        input  mem_we, mem_valid, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-lane select, sign/zero extension,
// read-modify-write for SB/SH, and fault detection, one registered response per request.
//   state  | meaning
//   IDLE   | ready; loads, SW and faults complete here; SB/SH read the word
//   RMW    | write back the merged word held from the accept cycle
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic                i_clk,
    input logic                i_rst,
    load_store_unit_if.slave   bus
);
    typedef enum logic {S_IDLE, S_RMW} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_misaligned;
    logic                  w_ok;
    logic                  w_is_sw;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [ADDR_WIDTH-1:0] r_hold_addr;
    logic [DATA_WIDTH-1:0] r_hold_word;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_misaligned;
    logic                  r_resp_illegal;

    assign w_accept    = bus.req_valid && (r_state == S_IDLE) && !i_rst;
    assign w_illegal   = bus.req_we ? (bus.req_funct3 > 3'd2)
                                    : (bus.req_funct3 == 3'd3 || bus.req_funct3[2:1] == 2'b11);
    assign w_misaligned = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                          (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    assign w_ok        = w_accept && !w_illegal && !w_misaligned;
    assign w_is_sw     = bus.req_we && (bus.req_funct3[1:0] == 2'b10);
    assign w_word_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_half      = bus.req_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (bus.req_addr[1:0])
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            2'd3:    w_byte = bus.mem_rdata[31:24];
            default: w_byte = bus.mem_rdata[7:0];
        endcase
    end

    always_comb begin
        w_load_data = bus.mem_rdata;
        case (bus.req_funct3)
            3'b000:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    // The store data is merged into the read word at accept, so RMW only replays the hold register.
    always_comb begin
        w_merged = bus.mem_rdata;
        if (bus.req_funct3[0]) begin
            if (bus.req_addr[1]) w_merged[31:16] = bus.req_wdata[15:0];
            else                 w_merged[15:0]  = bus.req_wdata[15:0];
        end else begin
            case (bus.req_addr[1:0])
                2'd0:    w_merged[7:0]   = bus.req_wdata[7:0];
                2'd1:    w_merged[15:8]  = bus.req_wdata[7:0];
                2'd2:    w_merged[23:16] = bus.req_wdata[7:0];
                default: w_merged[31:24] = bus.req_wdata[7:0];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_ok && bus.req_we && !w_is_sw) w_next = S_RMW;
            S_RMW:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (r_state == S_IDLE) && !i_rst;
        bus.mem_we    = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_ok) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_addr  = w_word_addr;
                    if (w_is_sw) begin
                        bus.mem_we    = 1'b1;
                        bus.mem_wdata = bus.req_wdata;
                    end
                end
            end
            S_RMW: begin
                if (!i_rst) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_valid = 1'b1;
                    bus.mem_addr  = r_hold_addr;
                    bus.mem_wdata = r_hold_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resp_valid      <= 1'b0;
            r_resp_rdata      <= '0;
            r_resp_misaligned <= 1'b0;
            r_resp_illegal    <= 1'b0;
            r_hold_addr       <= '0;
            r_hold_word       <= '0;
        end else begin
            r_resp_valid      <= 1'b0;
            r_resp_rdata      <= '0;
            r_resp_misaligned <= 1'b0;
            r_resp_illegal    <= 1'b0;
            if (w_accept) begin
                if (w_illegal) begin
                    r_resp_valid   <= 1'b1;
                    r_resp_illegal <= 1'b1;
                end else if (w_misaligned) begin
                    r_resp_valid      <= 1'b1;
                    r_resp_misaligned <= 1'b1;
                end else if (!bus.req_we) begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end else if (w_is_sw) begin
                    r_resp_valid <= 1'b1;
                end else begin
                    r_hold_addr <= w_word_addr;
                    r_hold_word <= w_merged;
                end
            end else if (r_state == S_RMW) begin
                r_resp_valid <= 1'b1;
            end
        end
    end

    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_rdata      = r_resp_rdata;
    assign bus.resp_misaligned = r_resp_misaligned;
    assign bus.resp_illegal    = r_resp_illegal;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic checked
// against a word-array reference model of memory and the load/store rules.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clear = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (bus.mem_valid && bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outcome of one request from the architectural rules, on the reference memory.
    task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                         output bit ill, output bit mis, output bit [31:0] rd, output bit [31:0] new_word);
        bit [31:0] w;
        bit [31:0] mask;
        bit [7:0]  b;
        bit [15:0] h;
        int size;
        int sh;
        w        = ref_mem[addr[7:2]];
        ill      = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        size     = 1 << f3[1:0];
        mis      = !ill && ((addr % size) != 0);
        sh       = (addr % 4) * 8;
        rd       = 32'd0;
        new_word = w;
        if (!ill && !mis) begin
            b = 8'(w >> sh);
            h = 16'(w >> sh);
            if (!we) begin
                case (f3)
                    3'd0:    rd = (b >= 8'd128) ? 32'(b) - 32'd256 : 32'(b);
                    3'd1:    rd = (h >= 16'd32768) ? 32'(h) - 32'h10000 : 32'(h);
                    3'd4:    rd = 32'(b);
                    3'd5:    rd = 32'(h);
                    default: rd = w;
                endcase
            end else begin
                mask     = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
                new_word = (w & ~(mask << sh)) | ((wd & mask) << sh);
            end
        end
    endtask

    // Starts at a falling edge, returns at the falling edge where the response is visible.
    // req_valid is left high so a following send() gives a back-to-back accept.
    task automatic send(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd);
        bit ill, mis, legal, is_sw, is_rmw;
        bit [31:0] rd, nw;
        model(we, f3, addr, wd, ill, mis, rd, nw);
        legal  = !ill && !mis;
        is_sw  = legal && we && (f3 == 3'd2);
        is_rmw = legal && we && (f3 != 3'd2);
        chk("ready_idle", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        #1;
        chk("acc_mem_we", bus.mem_we, is_sw);
        chk("acc_mem_valid", bus.mem_valid, legal);
        if (legal) chk("acc_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
        if (is_sw) chk("acc_mem_wdata", bus.mem_wdata, wd);
        @(posedge clk);
        @(negedge clk);
        if (is_rmw) begin
            bus.req_valid  = 1'b0;
            bus.req_we     = 1'($urandom);
            bus.req_funct3 = 3'($urandom);
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            chk("rmw_ready", bus.req_ready, 0);
            chk("rmw_resp_valid", bus.resp_valid, 0);
            chk("rmw_mem_we", bus.mem_we, 1);
            chk("rmw_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
            chk("rmw_mem_wdata", bus.mem_wdata, nw);
            @(posedge clk);
            @(negedge clk);
        end
        if (we && legal) ref_mem[addr[7:2]] = nw;
        chk("resp_valid", bus.resp_valid, 1);
        chk("resp_rdata", bus.resp_rdata, rd);
        chk("resp_misaligned", bus.resp_misaligned, mis);
        chk("resp_illegal", bus.resp_illegal, ill);
        last_rdata = bus.resp_rdata;
    endtask

    task automatic idle();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        #1;
        chk("idle_mem_we", bus.mem_we, 0);
        chk("idle_mem_valid", bus.mem_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("idle_resp_valid", bus.resp_valid, 0);
        chk("idle_resp_rdata", bus.resp_rdata, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        // Reset held for two cycles
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_mis", bus.resp_misaligned, 0);
        chk("rst_resp_ill", bus.resp_illegal, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_ready", bus.req_ready, 0);
        rst = 1'b0;
        mem_clear = 1'b0;
        #1;
        chk("ready_after_rst", bus.req_ready, 1);
        @(negedge clk);

        // Word round-trip, back-to-back
        send(1, 3'd2, 32'h10, 32'hDEADBEEF);
        send(0, 3'd2, 32'h10, 32'h0);
        chk("lw_roundtrip", last_rdata, 32'hDEADBEEF);
        idle();

        // Sub-word loads
        send(1, 3'd2, 32'h20, 32'h80FF7F01);
        send(0, 3'd0, 32'h23, 32'h0);
        chk("lb_const", last_rdata, 32'hFFFFFF80);
        send(0, 3'd4, 32'h23, 32'h0);
        chk("lbu_const", last_rdata, 32'h00000080);
        send(0, 3'd1, 32'h22, 32'h0);
        chk("lh_const", last_rdata, 32'hFFFF80FF);
        send(0, 3'd5, 32'h20, 32'h0);
        chk("lhu_const", last_rdata, 32'h00007F01);
        idle();

        // Read-modify-write, then load of the same word right after
        send(1, 3'd2, 32'h30, 32'h11223344);
        send(1, 3'd0, 32'h31, 32'hFFFFFFAA);
        chk("sb_mem", mem[12], 32'h1122AA44);
        send(1, 3'd1, 32'h32, 32'h1234BEEF);
        chk("sh_mem", mem[12], 32'hBEEFAA44);
        send(0, 3'd2, 32'h30, 32'h0);
        chk("load_after_rmw", last_rdata, 32'hBEEFAA44);
        idle();

        // Faults
        send(1, 3'd2, 32'h04, 32'hCAFEF00D);
        send(0, 3'd2, 32'h06, 32'h0);
        send(1, 3'd1, 32'h05, 32'h5555);
        send(0, 3'd3, 32'h04, 32'h0);
        send(1, 3'd4, 32'h05, 32'h77);
        chk("fault_ill_no_mis", bus.resp_misaligned, 0);
        idle();
        chk("fault_mem_unchanged", mem[1], 32'hCAFEF00D);

        // Reset during the RMW write cycle
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h31;
        bus.req_wdata  = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rmwrst_mem_we", bus.mem_we, 0);
        chk("rmwrst_mem_valid", bus.mem_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rmwrst_resp_valid", bus.resp_valid, 0);
        rst = 1'b0;
        #1;
        chk("rmwrst_ready", bus.req_ready, 1);
        chk("rmwrst_mem", mem[12], 32'hBEEFAA44);
        @(negedge clk);
        chk("rmwrst_no_resp", bus.resp_valid, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(1'($urandom), 3'($urandom), 32'($urandom_range(0, 255)), $urandom);
        end
        idle();

        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
